// File: rtl/noc_cycle_sequencer_pkg.sv
// Shared constants for the NoC cycle sequencer.
// Op codes broadcast to routers and the FSM state encoding.
package noc_cycle_sequencer_pkg;

   localparam int unsigned OP_NOP        = 0;
   localparam int unsigned OP_LOAD       = 1;
   localparam int unsigned OP_PHASE_BASE = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_PH   = 2'd2
   } state_e;

endpackage

// File: rtl/noc_cycle_sequencer_if.sv
// Router-array side of the sequencer: staging buses, done flags, op.
// master = sequencer, slave = router array.
interface noc_cycle_sequencer_if #(
   parameter int NUM_ROUTERS = 8,
   parameter int NUM_PORTS   = 5,
   parameter int FLIT_W      = 32,
   parameter int OP_W        = 3
);
   localparam int BUS_W = NUM_ROUTERS * NUM_PORTS * FLIT_W;

   logic [BUS_W-1:0]       out_staging;
   logic [BUS_W-1:0]       out_cr_staging;
   logic [NUM_ROUTERS-1:0] router_done;
   logic [BUS_W-1:0]       in_staging;
   logic [BUS_W-1:0]       in_cr_staging;
   logic [OP_W-1:0]        op;

   modport master (
      input  out_staging, out_cr_staging, router_done,
      output in_staging, in_cr_staging, op
   );

   modport slave (
      output out_staging, out_cr_staging, router_done,
      input  in_staging, in_cr_staging, op
   );
endinterface

// File: rtl/noc_link_xfer.sv
// Combinational gather of flits (src->dst) and credits (dst->src)
// through the link table; lowest source index wins a shared destination.
module noc_link_xfer #(
   parameter int NUM_ROUTERS = 8,
   parameter int NUM_PORTS   = 5,
   parameter int FLIT_W      = 32,
   parameter int IDX_W       = 6
) (
   input  logic [NUM_ROUTERS*NUM_PORTS-1:0]            link_vld_i,
   input  logic [NUM_ROUTERS*NUM_PORTS-1:0][IDX_W-1:0] link_dst_i,
   input  logic [NUM_ROUTERS*NUM_PORTS*FLIT_W-1:0]     out_flit_i,
   input  logic [NUM_ROUTERS*NUM_PORTS*FLIT_W-1:0]     out_cr_i,
   output logic [NUM_ROUTERS*NUM_PORTS*FLIT_W-1:0]     flit_o,
   output logic [NUM_ROUTERS*NUM_PORTS*FLIT_W-1:0]     cr_o
);
   localparam int S = NUM_ROUTERS * NUM_PORTS;

   always_comb begin
      flit_o = '0;
      cr_o   = '0;
      // descending scan so the lowest matching source is assigned last
      for (int d = 0; d < S; d++) begin
         for (int s = S - 1; s >= 0; s--) begin
            if (link_vld_i[s] && int'(link_dst_i[s]) == d) begin
               flit_o[d*FLIT_W +: FLIT_W] = out_flit_i[s*FLIT_W +: FLIT_W];
            end
         end
      end
      for (int s = 0; s < S; s++) begin
         for (int d = 0; d < S; d++) begin
            if (link_vld_i[s] && int'(link_dst_i[s]) == d) begin
               cr_o[s*FLIT_W +: FLIT_W] = out_cr_i[d*FLIT_W +: FLIT_W];
            end
         end
      end
   end
endmodule

// File: rtl/noc_cycle_sequencer.sv
// NoC cycle sequencer: link table, LOAD + phase stepping, run control.
// Staging registers capture the link gather on the edge leaving LOAD.
module noc_cycle_sequencer
   import noc_cycle_sequencer_pkg::*;
#(
   parameter int NUM_ROUTERS = 8,
   parameter int NUM_PORTS   = 5,
   parameter int FLIT_W      = 32,
   parameter int NUM_PHASES  = 2,
   parameter int CYC_W       = 16,
   parameter int OP_W        = 3,
   localparam int RW = $clog2(NUM_ROUTERS),
   localparam int PW = $clog2(NUM_PORTS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_we_i,
   input  logic [RW-1:0]    cfg_src_r_i,
   input  logic [PW-1:0]    cfg_src_p_i,
   input  logic [RW-1:0]    cfg_dst_r_i,
   input  logic [PW-1:0]    cfg_dst_p_i,
   input  logic             cfg_valid_i,
   input  logic             start_i,
   input  logic [CYC_W-1:0] run_cycles_i,
   input  logic             stop_i,
   output logic [CYC_W-1:0] in_cycle_o,
   output logic             busy_o,
   output logic             finished_o,
   output logic             all_done_o,
   noc_cycle_sequencer_if.master rt
);
   localparam int S     = NUM_ROUTERS * NUM_PORTS;
   localparam int BUS_W = S * FLIT_W;
   localparam int IDX_W = $clog2(S);
   localparam int PH_W  = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;

   state_e                      state_q, state_d;
   logic [PH_W-1:0]             phase_q, phase_d;
   logic [CYC_W-1:0]            in_cycle_q, in_cycle_d;
   logic [CYC_W-1:0]            target_q, target_d;
   logic                        stop_q, stop_d;
   logic                        finished_q, finished_d;
   logic                        all_done_q, all_done_d;
   logic [OP_W-1:0]             op_q, op_d;
   logic [BUS_W-1:0]            in_stg_q, in_cr_q;
   logic [BUS_W-1:0]            xfer_flit, xfer_cr;
   logic                        stage_ld;
   logic [S-1:0]                link_vld_q;
   logic [S-1:0][IDX_W-1:0]     link_dst_q;
   logic                        cfg_ok;
   logic [IDX_W-1:0]            cfg_src, cfg_dst;
   logic [CYC_W-1:0]            cyc_inc;
   logic                        last_ph;
   logic                        exit_run;

   assign cfg_src = IDX_W'(int'(cfg_src_r_i) * NUM_PORTS + int'(cfg_src_p_i));
   assign cfg_dst = IDX_W'(int'(cfg_dst_r_i) * NUM_PORTS + int'(cfg_dst_p_i));

   // out-of-range router/port codes are dropped rather than aliased
   assign cfg_ok = cfg_we_i && (state_q == ST_IDLE)
                && (int'(cfg_src_r_i) < NUM_ROUTERS)
                && (int'(cfg_dst_r_i) < NUM_ROUTERS)
                && (int'(cfg_src_p_i) < NUM_PORTS)
                && (int'(cfg_dst_p_i) < NUM_PORTS);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         link_vld_q <= '0;
         link_dst_q <= '0;
      end else if (cfg_ok) begin
         link_vld_q[cfg_src] <= cfg_valid_i;
         link_dst_q[cfg_src] <= cfg_dst;
      end
   end

   noc_link_xfer #(
      .NUM_ROUTERS (NUM_ROUTERS),
      .NUM_PORTS   (NUM_PORTS),
      .FLIT_W      (FLIT_W),
      .IDX_W       (IDX_W)
   ) u_xfer (
      .link_vld_i (link_vld_q),
      .link_dst_i (link_dst_q),
      .out_flit_i (rt.out_staging),
      .out_cr_i   (rt.out_cr_staging),
      .flit_o     (xfer_flit),
      .cr_o       (xfer_cr)
   );

   assign cyc_inc = in_cycle_q + 1'b1;
   assign last_ph = (int'(phase_q) == NUM_PHASES - 1);
   assign exit_run = ((target_q != '0) && (cyc_inc == target_q))
                  || ((target_q == '0) && (&rt.router_done))
                  || stop_q || stop_i;

   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      in_cycle_d = in_cycle_q;
      target_d   = target_q;
      stop_d     = stop_q;
      finished_d = 1'b0;
      all_done_d = all_done_q;
      stage_ld   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d    = ST_LOAD;
               in_cycle_d = '0;
               target_d   = run_cycles_i;
               stop_d     = 1'b0;
            end
         end
         ST_LOAD: begin
            stop_d   = stop_q | stop_i;
            stage_ld = 1'b1;
            state_d  = ST_PH;
            phase_d  = '0;
         end
         ST_PH: begin
            stop_d = stop_q | stop_i;
            if (last_ph) begin
               in_cycle_d = cyc_inc;
               all_done_d = &rt.router_done;
               if (exit_run) begin
                  state_d    = ST_IDLE;
                  finished_d = 1'b1;
                  stop_d     = 1'b0;
               end else begin
                  state_d = ST_LOAD;
               end
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      op_d = OP_W'(OP_NOP);
      case (state_d)
         ST_LOAD: op_d = OP_W'(OP_LOAD);
         ST_PH:   op_d = OP_W'(OP_PHASE_BASE + int'(phase_d));
         default: op_d = OP_W'(OP_NOP);
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         phase_q    <= '0;
         in_cycle_q <= '0;
         target_q   <= '0;
         stop_q     <= 1'b0;
         finished_q <= 1'b0;
         all_done_q <= 1'b0;
         op_q       <= OP_W'(OP_NOP);
         in_stg_q   <= '0;
         in_cr_q    <= '0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         in_cycle_q <= in_cycle_d;
         target_q   <= target_d;
         stop_q     <= stop_d;
         finished_q <= finished_d;
         all_done_q <= all_done_d;
         op_q       <= op_d;
         if (stage_ld) begin
            in_stg_q <= xfer_flit;
            in_cr_q  <= xfer_cr;
         end
      end
   end

   assign rt.in_staging    = in_stg_q;
   assign rt.in_cr_staging = in_cr_q;
   assign rt.op            = op_q;
   assign in_cycle_o       = in_cycle_q;
   assign busy_o           = (state_q != ST_IDLE);
   assign finished_o       = finished_q;
   assign all_done_o       = all_done_q;
endmodule

// File: tb/tb_noc_cycle_sequencer.sv
// Directed bench for noc_cycle_sequencer on a 4-router, 2-port array.
// Each scenario task drives stimulus and checks its own results.
module tb_noc_cycle_sequencer;
   localparam int R = 4;
   localparam int P = 2;
   localparam int W = 32;
   localparam int S = R * P;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cfg_we_i = 1'b0;
   logic [1:0]  cfg_src_r_i = '0;
   logic [0:0]  cfg_src_p_i = '0;
   logic [1:0]  cfg_dst_r_i = '0;
   logic [0:0]  cfg_dst_p_i = '0;
   logic        cfg_valid_i = 1'b0;
   logic        start_i = 1'b0;
   logic [15:0] run_cycles_i = '0;
   logic        stop_i = 1'b0;
   logic [15:0] in_cycle_o;
   logic        busy_o;
   logic        finished_o;
   logic        all_done_o;

   int tests = 0;
   int fails = 0;

   noc_cycle_sequencer_if #(
      .NUM_ROUTERS(R), .NUM_PORTS(P), .FLIT_W(W), .OP_W(3)
   ) rif ();

   noc_cycle_sequencer #(
      .NUM_ROUTERS(R), .NUM_PORTS(P), .FLIT_W(W),
      .NUM_PHASES(2), .CYC_W(16), .OP_W(3)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cfg_we_i     (cfg_we_i),
      .cfg_src_r_i  (cfg_src_r_i),
      .cfg_src_p_i  (cfg_src_p_i),
      .cfg_dst_r_i  (cfg_dst_r_i),
      .cfg_dst_p_i  (cfg_dst_p_i),
      .cfg_valid_i  (cfg_valid_i),
      .start_i      (start_i),
      .run_cycles_i (run_cycles_i),
      .stop_i       (stop_i),
      .in_cycle_o   (in_cycle_o),
      .busy_o       (busy_o),
      .finished_o   (finished_o),
      .all_done_o   (all_done_o),
      .rt           (rif)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input int sr, input int sp,
                            input int dr, input int dp, input bit v);
      cfg_src_r_i = 2'(sr);
      cfg_src_p_i = 1'(sp);
      cfg_dst_r_i = 2'(dr);
      cfg_dst_p_i = 1'(dp);
      cfg_valid_i = v;
      cfg_we_i    = 1'b1;
      tick();
      cfg_we_i    = 1'b0;
   endtask

   task automatic cfg_ring();
      for (int r = 0; r < R; r++) cfg_write(r, 1, (r + 1) % R, 0, 1'b1);
   endtask

   task automatic set_ring_data();
      for (int s = 0; s < S; s++) begin
         if (s % P == 1) rif.out_staging[s*W +: W] = 32'(32'hA0 + s / P);
         else rif.out_staging[s*W +: W] = 32'(32'h50 + s);
         if (s % P == 0)
            rif.out_cr_staging[s*W +: W] = 32'(32'hC0 + ((s / P) + 3) % R);
         else rif.out_cr_staging[s*W +: W] = 32'(32'hE0 + s);
      end
   endtask

   task automatic run_wait(input logic [15:0] rc,
                           output int clocks, output bit ok);
      start_i      = 1'b1;
      run_cycles_i = rc;
      tick();
      start_i = 1'b0;
      clocks  = 1;
      ok      = 1'b0;
      while (clocks < 200) begin
         if (finished_o) begin
            ok = 1'b1;
            break;
         end
         tick();
         clocks++;
      end
   endtask

   task automatic test_reset();
      int n;
      bit ok;
      tests++;
      if (rif.op !== 3'd0 || busy_o !== 1'b0 || in_cycle_o !== 16'd0 ||
          finished_o !== 1'b0 || all_done_o !== 1'b0) begin
         fails++;
         $display("FAIL reset_state: op=%0d busy=%b cyc=%0d fin=%b ad=%b want 0",
                  rif.op, busy_o, in_cycle_o, finished_o, all_done_o);
      end
      tests++;
      if (rif.in_staging !== '0 || rif.in_cr_staging !== '0) begin
         fails++;
         $display("FAIL reset_staging: got %h / %h want 0",
                  rif.in_staging, rif.in_cr_staging);
      end
      cfg_ring();
      set_ring_data();
      start_i      = 1'b1;
      run_cycles_i = 16'd5;
      tick();
      start_i = 1'b0;
      n = 0;
      while (rif.op !== 3'd2 && n < 10) begin
         tick();
         n++;
      end
      tests++;
      if (rif.op !== 3'd2 || rif.in_staging[2*W +: W] !== 32'hA0) begin
         fails++;
         $display("FAIL reset_ph0_reach: op=%0d slot2=%h want 2 / a0",
                  rif.op, rif.in_staging[2*W +: W]);
      end
      rst_n = 1'b0;
      #1;
      tests++;
      if (rif.op !== 3'd0 || busy_o !== 1'b0 || rif.in_staging !== '0 ||
          rif.in_cr_staging !== '0 || in_cycle_o !== 16'd0) begin
         fails++;
         $display("FAIL reset_midrun: op=%0d busy=%b stg=%h want 0 0 0",
                  rif.op, busy_o, rif.in_staging);
      end
      tick();
      rst_n = 1'b1;
      tick();
      run_wait(16'd1, n, ok);
      tests++;
      if (!ok || rif.in_staging !== '0 || rif.in_cr_staging !== '0) begin
         fails++;
         $display("FAIL reset_table_cleared: ok=%b stg=%h cr=%h want 1 0 0",
                  ok, rif.in_staging, rif.in_cr_staging);
      end
   endtask

   task automatic test_ring();
      logic [2:0] ops [5];
      logic       fin [5];
      int         exp_ops [5] = '{1, 2, 3, 0, 0};
      int         nfin;
      logic [31:0] e;
      cfg_ring();
      set_ring_data();
      start_i      = 1'b1;
      run_cycles_i = 16'd1;
      tick();
      start_i = 1'b0;
      ops[0] = rif.op;
      fin[0] = finished_o;
      for (int k = 1; k < 5; k++) begin
         tick();
         ops[k] = rif.op;
         fin[k] = finished_o;
      end
      nfin = 0;
      for (int k = 0; k < 5; k++) begin
         tests++;
         if (ops[k] !== 3'(exp_ops[k])) begin
            fails++;
            $display("FAIL ring_op[%0d]: got %0d want %0d", k, ops[k], exp_ops[k]);
         end
         if (fin[k] === 1'b1) nfin++;
      end
      tests++;
      if (nfin != 1 || fin[3] !== 1'b1) begin
         fails++;
         $display("FAIL ring_finished: pulses=%0d at3=%b want 1 1", nfin, fin[3]);
      end
      tests++;
      if (in_cycle_o !== 16'd1) begin
         fails++;
         $display("FAIL ring_in_cycle: got %0d want 1", in_cycle_o);
      end
      for (int s = 0; s < S; s++) begin
         e = (s % P == 0) ? 32'(32'hA0 + ((s / P) + 3) % R) : 32'h0;
         tests++;
         if (rif.in_staging[s*W +: W] !== e) begin
            fails++;
            $display("FAIL ring_flit[%0d]: got %h want %h",
                     s, rif.in_staging[s*W +: W], e);
         end
         e = (s % P == 1) ? 32'(32'hC0 + s / P) : 32'h0;
         tests++;
         if (rif.in_cr_staging[s*W +: W] !== e) begin
            fails++;
            $display("FAIL ring_credit[%0d]: got %h want %h",
                     s, rif.in_cr_staging[s*W +: W], e);
         end
      end
   endtask

   task automatic test_until_done();
      int  n;
      bit  set;
      bit  ok;
      rif.router_done = 4'b0000;
      start_i      = 1'b1;
      run_cycles_i = 16'd0;
      tick();
      start_i = 1'b0;
      set = 1'b0;
      ok  = 1'b0;
      for (n = 0; n < 60; n++) begin
         if (finished_o) begin
            ok = 1'b1;
            break;
         end
         if (!set && in_cycle_o == 16'd3 && rif.op == 3'd1) begin
            tests++;
            if (all_done_o !== 1'b0) begin
               fails++;
               $display("FAIL done_before: all_done=%b want 0", all_done_o);
            end
            rif.router_done = 4'b1111;
            set = 1'b1;
         end
         tick();
      end
      tests++;
      if (!ok || in_cycle_o !== 16'd4 || all_done_o !== 1'b1) begin
         fails++;
         $display("FAIL until_done: ok=%b cyc=%0d all_done=%b want 1 4 1",
                  ok, in_cycle_o, all_done_o);
      end
      rif.router_done = 4'b0000;
      tick();
   endtask

   task automatic test_stop();
      int  n;
      int  after;
      bit  sent;
      bit  ok;
      stop_i = 1'b1;
      tick();
      stop_i = 1'b0;
      run_wait(16'd2, n, ok);
      tests++;
      if (!ok || in_cycle_o !== 16'd2) begin
         fails++;
         $display("FAIL stop_idle_ignored: ok=%b cyc=%0d want 1 2", ok, in_cycle_o);
      end
      tick();
      start_i      = 1'b1;
      run_cycles_i = 16'd10;
      tick();
      start_i = 1'b0;
      sent  = 1'b0;
      ok    = 1'b0;
      after = 0;
      for (n = 0; n < 100; n++) begin
         stop_i = 1'b0;
         if (finished_o) begin
            ok = 1'b1;
            break;
         end
         if (!sent && in_cycle_o == 16'd2 && rif.op == 3'd2) begin
            stop_i = 1'b1;
            sent = 1'b1;
         end
         tick();
         if (sent) after++;
      end
      stop_i = 1'b0;
      tests++;
      if (!ok || in_cycle_o !== 16'd3) begin
         fails++;
         $display("FAIL stop_cycle: ok=%b cyc=%0d want 1 3", ok, in_cycle_o);
      end
      tests++;
      if (after != 2) begin
         fails++;
         $display("FAIL stop_latency: got %0d clocks want 2", after);
      end
      tick();
      tests++;
      if (busy_o !== 1'b0 || finished_o !== 1'b0) begin
         fails++;
         $display("FAIL stop_idle: busy=%b fin=%b want 0 0", busy_o, finished_o);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      bit ok;
      for (int k = 0; k < 2; k++) begin
         run_wait(16'd3, n, ok);
         tests++;
         if (!ok || n != 10 || in_cycle_o !== 16'd3) begin
            fails++;
            $display("FAIL b2b_run%0d: ok=%b clocks=%0d cyc=%0d want 1 10 3",
                     k, ok, n, in_cycle_o);
         end
      end
      tick();
   endtask

   task automatic test_conflict();
      int n;
      bit ok;
      set_ring_data();
      rif.out_staging[0*W +: W]    = 32'h11;
      rif.out_staging[6*W +: W]    = 32'h66;
      rif.out_cr_staging[5*W +: W] = 32'h55;
      cfg_write(0, 0, 2, 1, 1'b1);
      cfg_write(3, 0, 2, 1, 1'b1);
      run_wait(16'd1, n, ok);
      tests++;
      if (!ok || rif.in_staging[5*W +: W] !== 32'h11) begin
         fails++;
         $display("FAIL conflict_flit: got %h want 11", rif.in_staging[5*W +: W]);
      end
      tests++;
      if (rif.in_cr_staging[0*W +: W] !== 32'h55 ||
          rif.in_cr_staging[6*W +: W] !== 32'h55) begin
         fails++;
         $display("FAIL conflict_credit: got %h %h want 55 55",
                  rif.in_cr_staging[0*W +: W], rif.in_cr_staging[6*W +: W]);
      end
      tick();
      rif.out_staging[0*W +: W] = 32'h12;
      start_i      = 1'b1;
      run_cycles_i = 16'd1;
      tick();
      start_i = 1'b0;
      cfg_write(0, 0, 2, 1, 1'b0);
      ok = 1'b0;
      for (n = 0; n < 20; n++) begin
         if (finished_o) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      tick();
      run_wait(16'd1, n, ok);
      tests++;
      if (!ok || rif.in_staging[5*W +: W] !== 32'h12) begin
         fails++;
         $display("FAIL cfg_busy_ignored: got %h want 12",
                  rif.in_staging[5*W +: W]);
      end
      tick();
      cfg_write(0, 0, 2, 1, 1'b0);
      run_wait(16'd1, n, ok);
      tests++;
      if (!ok || rif.in_staging[5*W +: W] !== 32'h66 ||
          rif.in_cr_staging[0*W +: W] !== 32'h0) begin
         fails++;
         $display("FAIL cfg_idle_write: flit=%h cr=%h want 66 0",
                  rif.in_staging[5*W +: W], rif.in_cr_staging[0*W +: W]);
      end
      tick();
   endtask

   initial begin
      rif.out_staging    = '0;
      rif.out_cr_staging = '0;
      rif.router_done    = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      test_reset();
      test_ring();
      test_until_done();
      test_stop();
      test_back_to_back();
      test_conflict();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
